hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline sequencer for the 5-stage RISC-V core: decides each cycle which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold or flush. Merges three hazard sources: memory-response stalls, EX-stage taken branches/jumps, and load-use dependencies. Supersedes the standalone IF/ID flush sequencer by owning the multi-cycle flush window with a counter-driven FSM. Sits beside the datapath; all outputs go straight to pipeline-register enables/clears.

## Interface
- FLUSH_CYCLES, 2, cycles IF/ID is flushed after a redirect (covers imem latency); legal 1..7
- REG_W, 5, register-index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_read  in  1  fetch request outstanding
- imem_resp  in  1  fetch data valid this cycle
- dmem_access  in  1  MEM-stage load/store outstanding
- dmem_resp  in  1  data memory response this cycle
- br_taken  in  1  EX-stage branch/jump redirect
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  REG_W  EX destination register
- id_rs1, id_rs2  in  REG_W  ID source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1  register enables
- if_id_flush, id_ex_flush  out  1  synchronous bubble insert on next edge
- stall_cycles, flush_events  out  32  perf counters (only with HAZARD_PERF_EN)

## Operation
- mem_stall = (imem_read & ~imem_resp) | (dmem_access & ~dmem_resp).
- load_use = ex_is_load & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- FSM states: RUN, FLUSH. Counter flush_cnt, 3 bits.
- Priority per cycle, highest first:
  - mem_stall: all loads 0, all flushes 0; state and flush_cnt hold. br_taken stays pending (EX frozen), acted on release cycle.
  - br_taken: all loads 1, if_id_flush=1, id_ex_flush=1; next state FLUSH with flush_cnt=FLUSH_CYCLES-1 (if FLUSH_CYCLES==1, stay RUN). Valid from RUN or FLUSH (reloads counter).
  - state FLUSH: all loads 1, if_id_flush=1, id_ex_flush=0; flush_cnt decrements; at flush_cnt==0 next state RUN. load_use ignored (ID holds a bubble).
  - load_use (RUN only): pc_load=0, if_id_load=0, id_ex_flush=1, id_ex_load/ex_mem_load/mem_wb_load=1.
  - otherwise: all loads 1, flushes 0.
- ex_rd==x0 never triggers load_use.

## Timing
- Outputs combinational from state, flush_cnt and inputs; zero-cycle latency.
- While rst_n low: state RUN, flush_cnt 0, all *_load 0, both flushes 1, counters 0.
- Reset deassert: first cycle behaves as RUN.
- Redirect cost: branch cycle plus FLUSH_CYCLES-1 FLUSH cycles of if_id_flush (2 total at default).
- Load-use bubble: exactly one cycle; next cycle load_use false (load now in MEM).
- Reset mid-FLUSH: window aborted, RUN immediately.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles increments every mem_stall or load_use cycle; flush_events increments once per accepted br_taken (not while mem_stall); both wrap at 2^32.
- Undefined: ports, counters and logic absent.

## Structure
- Shared package pipe_pkg: hazard_state_t enum (RUN, FLUSH), FLUSH_CNT_W localparam, stage-enable struct stage_ctrl_t.
- One sub-module: hazard_detect (combinational load_use comparator), reused by forwarding logic.

## Test plan
- Reset held 3 cycles -> all loads 0, both flushes 1; release -> all loads 1, flushes 0.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_load=0, if_id_load=0, id_ex_flush=1; next cycle normal; repeat with ex_rd=0 -> no stall.
- br_taken one cycle, FLUSH_CYCLES=2 -> if_id_flush high 2 cycles, id_ex_flush 1 cycle, flush_events=1.
- br_taken with dmem_access=1, dmem_resp=0 for 4 cycles -> all loads 0 for 4 cycles, flush applied on 5th, stall_cycles=4.
- Second br_taken during FLUSH -> counter reloads, if_id_flush held FLUSH_CYCLES cycles after second branch.
- rst_n pulsed low mid-FLUSH -> state RUN, counters 0, no residual flush after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard FSM states, flush counter width
// and the per-cycle stage enable/clear bundle.
package pipe_pkg;

   localparam int FLUSH_CNT_W = 3;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hazard_state_t;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
      logic if_id_flush;
      logic id_ex_flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTL_RESET = '{
      pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0,
      mem_wb: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1};

   localparam stage_ctrl_t CTL_RUN = '{
      pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1,
      mem_wb: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load writing a register the ID
// instruction reads. x0 never counts as a dependency.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   output logic             load_use
);

   logic w_rd_nz;
   logic w_hit1;
   logic w_hit2;

   assign w_rd_nz  = |ex_rd;
   assign w_hit1   = id_use_rs1 && (id_rs1 == ex_rd);
   assign w_hit2   = id_use_rs2 && (id_rs2 == ex_rd);
   assign load_use = ex_is_load && w_rd_nz && (w_hit1 || w_hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: merges memory stalls, redirects and load-use
// into register enables/clears. Perf counters under HAZARD_PERF_EN.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_W        = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_access,
   input  logic             dmem_resp,
   input  logic             br_taken,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
`ifdef HAZARD_PERF_EN
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_events,
`endif
   output logic             if_id_flush,
   output logic             id_ex_flush
);

   localparam logic [FLUSH_CNT_W-1:0] CNT_RELOAD =
      FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [FLUSH_CNT_W-1:0] CNT_ONE = FLUSH_CNT_W'(1);

   hazard_state_t          r_state;
   hazard_state_t          w_state_nxt;
   logic [FLUSH_CNT_W-1:0] r_cnt;
   logic [FLUSH_CNT_W-1:0] w_cnt_nxt;
   stage_ctrl_t            w_ctl;
   logic                   w_mem_stall;
   logic                   w_load_use;
   logic                   w_lu_stall;
   logic                   w_br_accept;

   hazard_detect #(.REG_W(REG_W)) u_detect (
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .load_use   (w_load_use)
   );

   assign w_mem_stall = (imem_read && !imem_resp) ||
                        (dmem_access && !dmem_resp);
   assign w_br_accept = br_taken && !w_mem_stall;
   assign w_lu_stall  = w_load_use && !w_mem_stall &&
                        !br_taken && (r_state == RUN);

   // Hazard priority: mem stall, redirect, flush window, load-use
   always_comb begin
      w_ctl       = CTL_RUN;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!rst_n) begin
         w_ctl = CTL_RESET;
      end else if (w_mem_stall) begin
         w_ctl = '0;
      end else if (br_taken) begin
         w_ctl.if_id_flush = 1'b1;
         w_ctl.id_ex_flush = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = CNT_RELOAD;
         end else begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      end else if (r_state == FLUSH) begin
         w_ctl.if_id_flush = 1'b1;
         if (r_cnt <= CNT_ONE) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
         end
      end else if (w_load_use) begin
         w_ctl.pc          = 1'b0;
         w_ctl.if_id       = 1'b0;
         w_ctl.id_ex_flush = 1'b1;
      end
   end

   // FSM state and flush window counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   // Stall and redirect event counters, wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (w_mem_stall || w_lu_stall)
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_br_accept)
            r_flush_events <= r_flush_events + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`else
   logic w_unused;
   assign w_unused = w_lu_stall ^ w_br_accept;
`endif

   assign pc_load     = w_ctl.pc;
   assign if_id_load  = w_ctl.if_id;
   assign id_ex_load  = w_ctl.id_ex;
   assign ex_mem_load = w_ctl.ex_mem;
   assign mem_wb_load = w_ctl.mem_wb;
   assign if_id_flush = w_ctl.if_id_flush;
   assign id_ex_flush = w_ctl.id_ex_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, corner sequences and random
// traffic against a pending-flush-count reference model.
module tb_hazard_ctrl;

   localparam int FC = 2;
   localparam int RW = 5;

   typedef struct {
      logic          rst_n;
      logic          ir;
      logic          irsp;
      logic          da;
      logic          drsp;
      logic          br;
      logic          ld;
      logic [RW-1:0] rd;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic          u1;
      logic          u2;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [6:0] exp;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          imem_read, imem_resp;
   logic          dmem_access, dmem_resp;
   logic          br_taken, ex_is_load;
   logic [RW-1:0] ex_rd, id_rs1, id_rs2;
   logic          id_use_rs1, id_use_rs2;
   logic          pc_load, if_id_load, id_ex_load;
   logic          ex_mem_load, mem_wb_load;
   logic          if_id_flush, id_ex_flush;
`ifdef HAZARD_PERF_EN
   logic [31:0]   stall_cycles, flush_events;
`endif

   int checks   = 0;
   int failures = 0;
   int m_pend   = 0;
   int m_stall  = 0;
   int m_flush  = 0;

   hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(RW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_read   (imem_read),
      .imem_resp   (imem_resp),
      .dmem_access (dmem_access),
      .dmem_resp   (dmem_resp),
      .br_taken    (br_taken),
      .ex_is_load  (ex_is_load),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .pc_load     (pc_load),
      .if_id_load  (if_id_load),
      .id_ex_load  (id_ex_load),
      .ex_mem_load (ex_mem_load),
      .mem_wb_load (mem_wb_load),
`ifdef HAZARD_PERF_EN
      .stall_cycles(stall_cycles),
      .flush_events(flush_events),
`endif
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '{rst_n: 1'b1, ir: 1'b0, irsp: 1'b0, da: 1'b0,
            drsp: 1'b0, br: 1'b0, ld: 1'b0, rd: '0, rs1: '0,
            rs2: '0, u1: 1'b0, u2: 1'b0};
      return s;
   endfunction

   function automatic stim_t lu(input int rd, input int r1,
                                input int r2, input bit a,
                                input bit b);
      stim_t s;
      s     = idle();
      s.ld  = 1'b1;
      s.rd  = RW'(rd);
      s.rs1 = RW'(r1);
      s.rs2 = RW'(r2);
      s.u1  = a;
      s.u2  = b;
      return s;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp,
                  $time);
      end
   endtask

   // Drive one cycle, check against model (and table value when
   // given), then advance the model across the clock edge.
   task automatic step(input stim_t s, input string nm,
                       input bit use_tab, input logic [6:0] tab);
      logic [6:0] mexp;
      logic [6:0] got;
      bit         ms, luse, stall_now;
      rst_n       = s.rst_n;
      imem_read   = s.ir;
      imem_resp   = s.irsp;
      dmem_access = s.da;
      dmem_resp   = s.drsp;
      br_taken    = s.br;
      ex_is_load  = s.ld;
      ex_rd       = s.rd;
      id_rs1      = s.rs1;
      id_rs2      = s.rs2;
      id_use_rs1  = s.u1;
      id_use_rs2  = s.u2;
      #3;
      ms   = (s.ir && !s.irsp) || (s.da && !s.drsp);
      luse = s.ld && (s.rd != 0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      stall_now = 1'b0;
      if (!s.rst_n) mexp = 7'b00000_11;
      else if (ms) mexp = 7'b00000_00;
      else if (s.br) mexp = 7'b11111_11;
      else if (m_pend > 0) mexp = 7'b11111_10;
      else if (luse) mexp = 7'b00111_01;
      else mexp = 7'b11111_00;
      if (s.rst_n && (ms || (luse && !s.br && m_pend == 0)))
         stall_now = 1'b1;
      got = {pc_load, if_id_load, id_ex_load, ex_mem_load,
             mem_wb_load, if_id_flush, id_ex_flush};
      cmp({nm, "_model"}, 32'(got), 32'(mexp));
      if (use_tab) cmp({nm, "_table"}, 32'(got), 32'(tab));
`ifdef HAZARD_PERF_EN
      cmp({nm, "_stallcnt"}, stall_cycles, 32'(m_stall));
      cmp({nm, "_flushcnt"}, flush_events, 32'(m_flush));
`endif
      @(posedge clk);
      #1;
      if (!s.rst_n) begin
         m_pend  = 0;
         m_stall = 0;
         m_flush = 0;
      end else if (!ms) begin
         if (s.br) begin
            m_pend = FC - 1;
            m_flush++;
         end else if (m_pend > 0) begin
            m_pend--;
         end
      end
      if (stall_now) m_stall++;
   endtask

   vec_t  tv[$];
   stim_t s;

   initial begin
      s = idle();
      s.rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(s, "reset", 1, 7'b00000_11);

      tv.push_back('{idle(), 7'b11111_00});
      tv.push_back('{lu(5, 0, 5, 0, 1), 7'b00111_01});
      tv.push_back('{idle(), 7'b11111_00});
      tv.push_back('{lu(0, 0, 0, 0, 1), 7'b11111_00});
      tv.push_back('{lu(3, 3, 0, 0, 0), 7'b11111_00});
      tv.push_back('{lu(3, 3, 0, 1, 0), 7'b00111_01});
      s = idle(); s.ir = 1'b1;
      tv.push_back('{s, 7'b00000_00});
      s.irsp = 1'b1;
      tv.push_back('{s, 7'b11111_00});
      s = idle(); s.da = 1'b1; s.br = 1'b1;
      tv.push_back('{s, 7'b00000_00});
      s.drsp = 1'b1;
      tv.push_back('{s, 7'b11111_11});
      tv.push_back('{idle(), 7'b11111_10});
      tv.push_back('{lu(7, 7, 7, 1, 1), 7'b00111_01});
      s = idle(); s.br = 1'b1;
      tv.push_back('{s, 7'b11111_11});
      tv.push_back('{lu(7, 7, 7, 1, 1), 7'b11111_10});
      tv.push_back('{idle(), 7'b11111_00});
      foreach (tv[i]) step(tv[i].s, $sformatf("vec%0d", i), 1,
                           tv[i].exp);

      // Branch held under a 4-cycle data-memory stall
      s = idle(); s.da = 1'b1; s.br = 1'b1;
      for (int i = 0; i < 4; i++) step(s, "brstall", 1, 7'b0);
      s.drsp = 1'b1;
      step(s, "brrelease", 1, 7'b11111_11);
      step(idle(), "brflush", 1, 7'b11111_10);
      step(idle(), "brdone", 1, 7'b11111_00);

      // Second branch inside the flush window reloads it
      s = idle(); s.br = 1'b1;
      step(s, "br1", 1, 7'b11111_11);
      step(s, "br2", 1, 7'b11111_11);
      step(idle(), "br2flush", 1, 7'b11111_10);
      step(idle(), "br2done", 1, 7'b11111_00);

      // Reset pulse in the middle of a flush window
      step(s, "brrst", 1, 7'b11111_11);
      s = idle(); s.rst_n = 1'b0;
      step(s, "midrst", 1, 7'b00000_11);
      step(idle(), "postrst", 1, 7'b11111_00);
      step(idle(), "postrst2", 1, 7'b11111_00);

      for (int n = 0; n < 1500; n++) begin
         s.rst_n = ($urandom_range(0, 99) != 0);
         s.ir    = 1'($urandom_range(0, 3) == 0);
         s.irsp  = 1'($urandom_range(0, 2) != 0);
         s.da    = 1'($urandom_range(0, 3) == 0);
         s.drsp  = 1'($urandom_range(0, 2) != 0);
         s.br    = 1'($urandom_range(0, 5) == 0);
         s.ld    = 1'($urandom_range(0, 1));
         s.rd    = RW'($urandom_range(0, 3));
         s.rs1   = RW'($urandom_range(0, 3));
         s.rs2   = RW'($urandom_range(0, 3));
         s.u1    = 1'($urandom_range(0, 1));
         s.u2    = 1'($urandom_range(0, 1));
         step(s, "rand", 0, 7'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
